// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, 33-cycle stall (2 for divide-by-zero).
// No backpressure beyond the start/ready handshake: start is held until ready, then dropped to release.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BYZERO = 2'd1;
  localparam logic [1:0] ON     = 2'd2;
  localparam logic [1:0] END    = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] dvsr;
  logic              sgn_mode;
  logic              sgn1;
  logic              sgn2;

  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;
  logic              ge;
  logic [DATA_W-1:0] op1_abs;
  logic [DATA_W-1:0] op2_abs;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;

  always_comb begin
    trial   = {rem[DATA_W-1:0], quo[DATA_W-1]};
    diff    = trial - {1'b0, dvsr};
    ge      = (trial >= {1'b0, dvsr});
    // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
    op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    q_fix   = (sgn_mode && (sgn1 ^ sgn2)) ? -quo : quo;
    r_fix   = (sgn_mode && sgn1) ? -rem[DATA_W-1:0] : rem[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      sgn_mode <= 1'b0;
      sgn1     <= 1'b0;
      sgn2     <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (start_i && !annul_i) begin
            sgn_mode <= signed_div_i;
            sgn1     <= opdata1_i[DATA_W-1];
            sgn2     <= opdata2_i[DATA_W-1];
            quo      <= op1_abs;
            dvsr     <= op2_abs;
            rem      <= '0;
            cnt      <= '0;
            state    <= (opdata2_i == '0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          state    <= annul_i ? IDLE : END;
        end
        ON: begin
          if (annul_i) begin
            state   <= IDLE;
            ready_o <= 1'b0;
          end else if (cnt != CNT_W'(DATA_W)) begin
            rem <= ge ? diff : trial;
            quo <= {quo[DATA_W-2:0], ge};
            cnt <= cnt + CNT_W'(1);
          end else begin
            result_o <= {r_fix, q_fix};
            ready_o  <= 1'b1;
            state    <= END;
          end
        end
        default: begin
          // END: result holds while execute keeps start high; annul is ignored here.
          if (start_i) begin
            ready_o <= 1'b1;
          end else begin
            result_o <= '0;
            ready_o  <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU, serving the first-issue slot of the dual-issue execute stage.
- Execute drives operands, sign mode and start, and holds start until ready_o is seen, keeping the pipeline stalled meanwhile.
- The 64-bit {remainder, quotient} result returns to execute, which writes it to HI/LO.
- annul_i aborts an in-flight division when execute is flushed by an exception or redirect.

Parameters:
- DATA_W, 32, operand width; the result is 2*DATA_W wide.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset: synchronous, active-high.
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
- opdata1_i  input  DATA_W  dividend; sampled at start.
- opdata2_i  input  DATA_W  divisor; sampled at start.
- start_i  input  1  request; held high by execute until ready_o is observed.
- annul_i  input  1  abort current or pending operation.
- result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}.
- ready_o  output  1  result_o valid.

Behaviour:
- States: IDLE, BYZERO, ON, END. A 6-bit counter cnt (0..32) runs in ON.
- Reset: state=IDLE, cnt=0, result_o=0, ready_o=0. rst mid-operation returns to IDLE next edge and discards all work.
- IDLE: result_o=0, ready_o=0.
  - start_i=1 and annul_i=0 with opdata2_i==0 -> BYZERO.
  - start_i=1 and annul_i=0 with opdata2_i!=0 -> ON.
  - Otherwise stay in IDLE; start_i with annul_i in the same cycle is ignored.
- Operand capture on the IDLE->ON edge:
  - Latch the sign flag, the dividend sign (opdata1_i[31]) and the divisor sign (opdata2_i[31]).
  - In signed mode, latch the absolute values of both operands (two's-complement negate if negative); in unsigned mode latch them raw.
  - |0x80000000| = 0x80000000, treated as unsigned.
  - cnt=0, partial remainder R (33 bits) = 0, quotient shift register Q = latched dividend.
- ON, cnt<32, one step per cycle:
  - T = {R[31:0], Q[31]}; Q <<= 1.
  - If T >= {1'b0, divisor}: R = T - divisor and Q[0]=1; else R = T and Q[0]=0.
  - cnt++.
- ON, cnt==32: fix-up and go to END.
  - Quotient is negated if signed mode and the two operand signs differ.
  - Remainder is negated if signed mode and the dividend was negative.
  - Load result_o = {remainder, quotient}; ready_o=1.
- annul_i=1 in ON or BYZERO: go to IDLE next edge, ready_o stays 0, and the partial result is never exposed.
- BYZERO: next edge goes to END with result_o=0 and ready_o=1; the architecturally undefined result is fixed at 0.
- END:
  - result_o and ready_o hold stable while start_i=1.
  - start_i=0 -> IDLE next edge, with result_o=0 and ready_o=0 from that edge.
  - annul_i in END is ignored; execute drops start instead.
- Latency, start first sampled at edge N:
  - Nonzero divisor: steps occur at edges N+1..N+32, and ready_o is high after edge N+33 (33-cycle stall).
  - Divide by zero: ready_o is high after edge N+2.
- Operand changes after capture have no effect.
- A new operation requires passing through IDLE, i.e. start_i must be low for at least one cycle between operations.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, with no exception.

Test Plan:
- Unsigned 100/7, start held -> ready_o rises exactly 33 cycles after the start edge, result_o = {0x00000002, 0x0000000E}; drop start -> ready_o=0 and result_o=0 one cycle later.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF/1 -> {0x00000000, 0xFFFFFFFF}; result stable while start is held.
- Divisor 0 (either mode) -> ready_o after 2 cycles, result_o = 0.
- annul_i pulsed at cycle 10 of ON -> IDLE, ready_o never asserts. Follow with start 50/5 -> {0, 0x0000000A} after 33 cycles.
- rst asserted mid-ON, and start_i+annul_i together in IDLE -> state IDLE, outputs 0. Operands toggled during ON -> result unaffected.
